// File: rtl/rr_mux_arbiter16.sv
// Round-robin arbiter for a shared 16:1 bit-select mux: registered one-hot grant,
// binary select, and tenure counter with optional preemption after MAX_HOLD cycles.
module rr_mux_arbiter16 #(
  parameter int unsigned MAX_HOLD = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        valid,
  output logic [3:0]  hold_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  ptr_r, ptr_s;
  logic [15:0] gnt_s;
  logic [3:0]  sel_s;
  logic        valid_s;
  logic [3:0]  hold_s;

  logic [3:0]  base_s;
  logic [15:0] cand_s;
  logic [3:0]  win_s;
  logic        found_s;
  logic        others_s;
  logic        release_s;
  logic        preempt_s;

  // First set bit of r searching base, base+1, ... with 4-bit wrap; MSB flags a hit.
  // Iterating from the far end lets the nearest candidate overwrite the result.
  function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] base);
    logic [4:0] res;
    logic [3:0] idx;
    res = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = base + 4'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration candidates: a departing owner is masked and the search starts after it.
  always_comb begin
    others_s  = (req & ~(16'd1 << sel)) != 16'd0;
    release_s = (state_r == OWN) && !req[sel];
    preempt_s = (state_r == OWN) && (MAX_HOLD != 32'd0) &&
                (32'(hold_cnt) == MAX_HOLD) && others_s;
    if (state_r == OWN) begin
      base_s = sel + 4'd1;
      cand_s = req & ~(16'd1 << sel);
    end else begin
      base_s = ptr_r;
      cand_s = req;
    end
    {found_s, win_s} = rr_pick(cand_s, base_s);
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gnt_s   = gnt;
    sel_s   = sel;
    valid_s = valid;
    hold_s  = hold_cnt;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = OWN;
          gnt_s   = 16'd1 << win_s;
          sel_s   = win_s;
          valid_s = 1'b1;
          hold_s  = 4'd1;
        end else begin
          gnt_s   = 16'd0;
          valid_s = 1'b0;
          hold_s  = 4'd0;
        end
      end
      OWN: begin
        if (release_s || preempt_s) begin
          ptr_s = sel + 4'd1;
          if (found_s) begin
            gnt_s   = 16'd1 << win_s;
            sel_s   = win_s;
            valid_s = 1'b1;
            hold_s  = 4'd1;
          end else begin
            state_s = IDLE;
            gnt_s   = 16'd0;
            valid_s = 1'b0;
            hold_s  = 4'd0;
          end
        end else begin
          hold_s = (hold_cnt == 4'd15) ? 4'd15 : hold_cnt + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        ptr_s   = 4'd0;
        gnt_s   = 16'd0;
        sel_s   = 4'd0;
        valid_s = 1'b0;
        hold_s  = 4'd0;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      ptr_r    <= 4'd0;
      gnt      <= 16'd0;
      sel      <= 4'd0;
      valid    <= 1'b0;
      hold_cnt <= 4'd0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      gnt      <= gnt_s;
      sel      <= sel_s;
      valid    <= valid_s;
      hold_cnt <= hold_s;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter16.sv
// Self-checking bench for rr_mux_arbiter16: behavioural owner/pointer model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_rr_mux_arbiter16;

  localparam int MH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        valid;
  logic [3:0]  hold_cnt;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  int m_owner = -1;
  int m_ptr = 0;
  int m_hold = 0;
  int m_sel = 0;

  logic [15:0] rr_req [9] = '{16'h820A, 16'h820A, 16'h8208, 16'h820A, 16'h8202,
                              16'h820A, 16'h800A, 16'h820A, 16'h020A};
  int          rr_sel [9] = '{1, 1, 3, 3, 9, 9, 15, 15, 1};

  always #5 clk = ~clk;

  rr_mux_arbiter16 #(.MAX_HOLD(MH)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .gnt(gnt),
    .sel(sel),
    .valid(valid),
    .hold_cnt(hold_cnt)
  );

  function automatic int search(input logic [15:0] r, input int p, input int skip);
    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = (p + k) % 16;
      if (idx != skip && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [15:0] r, input logic rst);
    int w;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      w = search(r, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 1;
      end
    end else if (!r[m_owner] ||
                 (MH > 0 && m_hold == MH && (r & ~(16'd1 << m_owner)) != 16'd0)) begin
      m_ptr = (m_owner + 1) % 16;
      w = search(r, m_ptr, m_owner);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 1;
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end else begin
      m_hold = (m_hold < 15) ? m_hold + 1 : 15;
    end
  endtask

  task automatic cycle(input logic [15:0] r, input logic rst);
    req = r;
    reset = rst;
    @(posedge clk);
    model_step(r, rst);
    run = 1'b1;
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model plus structural invariants.
  always @(negedge clk) begin : cmp
    logic [15:0] eg;
    logic        ev;
    if (run) begin
      ev = (m_owner >= 0);
      eg = ev ? (16'd1 << m_owner) : 16'd0;
      checks++;
      if ({gnt, sel, valid, hold_cnt} !== {eg, 4'(m_sel), ev, 4'(m_hold)}) begin
        failures++;
        $display("FAIL model: gnt=%h sel=%0d valid=%b hold=%0d expected gnt=%h sel=%0d valid=%b hold=%0d at %0t",
                 gnt, sel, valid, hold_cnt, eg, m_sel, ev, m_hold, $time);
      end
      checks++;
      if ($countones(gnt) > 1 || (valid && !gnt[sel]) || (valid != (gnt != 16'd0))) begin
        failures++;
        $display("FAIL invariant: gnt=%h sel=%0d valid=%b expected onehot0 grant matching sel at %0t",
                 gnt, sel, valid, $time);
      end
    end
  end

  initial begin
    logic [15:0] rs;
    req = 16'd0;
    reset = 1'b1;

    // Reset with all requests high, then first grant from index 0.
    cycle(16'hFFFF, 1'b1);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_hold", 32'(hold_cnt), 32'h0);
    cycle(16'hFFFF, 1'b0);
    chk("first_gnt", 32'(gnt), 32'h0001);
    chk("first_sel", 32'(sel), 32'h0);

    // Single requester 5 for five cycles, then release leaves ptr at 6.
    cycle(16'h0000, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cycle(16'h0020, 1'b0);
      chk("single_gnt", 32'(gnt), 32'h0020);
      chk("single_hold", 32'(hold_cnt), 32'(i));
    end
    cycle(16'h0000, 1'b0);
    chk("single_idle_gnt", 32'(gnt), 32'h0);
    chk("single_idle_valid", 32'(valid), 32'h0);
    cycle(16'h0041, 1'b0);
    chk("ptr_after_release", 32'(sel), 32'd6);

    // Round-robin with wrap: 1, 3, 9, 15, 1 without bubbles.
    cycle(16'h0000, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle(rr_req[i], 1'b0);
      chk("rr_sel", 32'(sel), 32'(rr_sel[i]));
      chk("rr_valid", 32'(valid), 32'h1);
    end

    // Preemption after MAX_HOLD cycles, then owner 2 returns after 7 releases.
    cycle(16'h0000, 1'b1);
    cycle(16'h0004, 1'b0);
    cycle(16'h0004, 1'b0);
    for (int i = 0; i < 6; i++) cycle(16'h0084, 1'b0);
    chk("preempt_before_sel", 32'(sel), 32'd2);
    chk("preempt_before_hold", 32'(hold_cnt), 32'd8);
    cycle(16'h0084, 1'b0);
    chk("preempt_gnt", 32'(gnt), 32'h0080);
    chk("preempt_sel", 32'(sel), 32'd7);
    chk("preempt_hold", 32'(hold_cnt), 32'd1);
    rs = 16'h3F84;
    for (int i = 0; i < 7; i++) begin
      rs = rs & ~(16'd1 << m_owner);
      cycle(rs, 1'b0);
    end
    chk("regain_gnt", 32'(gnt), 32'h0004);
    chk("regain_sel", 32'(sel), 32'd2);

    // Lone requester: no preemption, hold saturates at 15.
    cycle(16'h0000, 1'b1);
    for (int i = 0; i < 20; i++) cycle(16'h0010, 1'b0);
    chk("alone_gnt", 32'(gnt), 32'h0010);
    chk("alone_hold", 32'(hold_cnt), 32'd15);

    // Reset mid-tenure clears ptr: owner 11 reached via release, then restart at 0.
    cycle(16'h0000, 1'b1);
    cycle(16'h0C00, 1'b0);
    cycle(16'h0800, 1'b0);
    cycle(16'h0800, 1'b0);
    chk("mid_owner", 32'(sel), 32'd11);
    cycle(16'h0801, 1'b1);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_sel", 32'(sel), 32'h0);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_hold", 32'(hold_cnt), 32'h0);
    cycle(16'h0801, 1'b0);
    chk("mid_restart_sel", 32'(sel), 32'd0);
    chk("mid_restart_gnt", 32'(gnt), 32'h0001);

    // Randomized traffic checked by the model every cycle.
    rs = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) rs = rs ^ (16'd1 << $urandom_range(15, 0));
      if ($urandom_range(49, 0) == 0) rs = 16'($urandom) & 16'($urandom);
      if (m_owner >= 0 && $urandom_range(9, 0) == 0) rs = rs & ~(16'd1 << m_owner);
      cycle(rs, ($urandom_range(199, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter16.md
Name: rr_mux_arbiter16

Overview:
- Round-robin arbiter that shares one 16:1 bit-select datapath among 16 requesters.
- Produces a one-hot grant and the 4-bit select that drives the shared 16:1 mux, which is instantiated outside this block.
- Grants are held while the owner keeps requesting, with optional bounded tenure for fairness.
- Sits between requester logic and the shared mux; has no data path of its own.

Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles for one owner while any other request is pending. 0 disables preemption (hold until release).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  16  request per requester; bit i high means requester i wants the mux. Held high for the whole tenure.
- gnt  output  16  one-hot grant, registered; all-zero when idle.
- sel  output  4  binary index of the current owner, registered; feeds the mux select.
- valid  output  1  high when gnt is non-zero (sel is meaningful).
- hold_cnt  output  4  cycles the current owner has held the grant, saturating at 15; 0 when idle (debug/verification visibility).

Behaviour:
- Reset (sampled at clk edge): gnt=0, sel=0, valid=0, hold_cnt=0, rotate pointer ptr=0, state=IDLE. Reset overrides everything, including mid-tenure; req on the reset cycle is ignored.
- State encoding: IDLE (no owner), OWN (owner = sel).
- Search order: indices ptr, ptr+1, ..., ptr+15, taken mod 16 (wraps 15->0). The first index with an eligible request wins.
- IDLE: if req != 0, the winner w is computed combinationally and registered at the edge. Next cycle: gnt=1<<w, sel=w, valid=1, hold_cnt=1, state=OWN.
  - Latency: req sampled at edge n, grant visible after edge n (one cycle).
  - If req == 0, stay IDLE with outputs unchanged. sel keeps its last value; gnt=0, valid=0.
- OWN, owner o:
  - Release: req[o]=0 at an edge. Set ptr=(o+1) mod 16 and re-arbitrate in the same cycle over req with bit o masked. If a winner exists, grant it at that edge (no bubble cycle, hold_cnt=1). Otherwise go to IDLE, with gnt=0, valid=0, hold_cnt=0.
  - Preempt: MAX_HOLD>0 and hold_cnt==MAX_HOLD and any req[j], j!=o. Handled exactly as release: ptr=(o+1) mod 16, o masked for this arbitration only. The preempted owner may win again later by rotation.
  - Continue: req[o]=1 and no preempt. Grant unchanged; hold_cnt increments, saturating at 15.
  - With MAX_HOLD>0 and no other requester pending, the owner keeps the grant indefinitely, even after hold_cnt reaches MAX_HOLD.
- ptr only changes on release or preempt (and reset). It is not changed by an initial grant from IDLE.
- Invariants:
  - gnt is 0 or exactly one-hot.
  - gnt[sel]==1 whenever valid=1.
  - Never grant a requester whose req was low at the deciding edge.
- Simultaneous requests are resolved solely by the search order from ptr.
- Requests asserted mid-tenure wait; at most 15 tenures pass before any continuously requesting index is served.

Test Plan:
- Reset with req=16'hFFFF -> gnt=0, sel=0, valid=0 for the reset cycle. After reset drops, next edge gives gnt=16'h0001, sel=0.
- Single requester: req=16'h0020 held 5 cycles then dropped -> gnt=16'h0020, sel=5 for 5 cycles, hold_cnt 1..5. Then gnt=0, valid=0, ptr=6.
- Round-robin with wrap: requesters 3, 9, 15 plus 1 held, each releasing after 2 cycles, starting ptr=0 -> grant order 1, 3, 9, 15, 1 with no idle bubble between tenures.
- Preemption, MAX_HOLD=8: req[2] held; req[7] raised at cycle 3 -> owner 2 keeps the grant for exactly 8 cycles, then gnt=16'h0080, sel=7. Owner 2 regains the grant after 7 releases.
- No contention, MAX_HOLD=8: req[4] held 20 cycles alone -> continuous grant; hold_cnt saturates at 15; no preemption.
- Reset mid-tenure: owner sel=11, reset pulsed for 1 cycle -> all outputs and ptr cleared at that edge. Re-arbitration restarts from index 0.
